counter_hours: RTL and testbench

COUNTER_HOURS -- requirements
Module: counter_hours

---
 rtl/counter_hours_if.sv | 21 ++
 rtl/counter_hours.sv | 106 ++++++++++
 tb/tb_counter_hours.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_hours_if.sv
// Hour-counter signal bundle: minutes carry, manual-set controls and the registered hour outputs.
// The master modport drives the stimulus; the slave modport is the counter side.
interface counter_hours_if;
  logic       carry_in;
  logic       set_en;
  logic       adj_in;
  logic [3:0] hour_digit1;
  logic [1:0] hour_digit2;
  logic       day_pulse;
  logic       pm;

  modport master (
    output carry_in, set_en, adj_in,
    input  hour_digit1, hour_digit2, day_pulse, pm
  );

  modport slave (
    input  carry_in, set_en, adj_in,
    output hour_digit1, hour_digit2, day_pulse, pm
  );
endinterface

// File: rtl/counter_hours.sv
// BCD hour counter advanced by rising edges of the minutes carry, or by a manual adjust input
// while in set mode. Default build counts 00..23; defining TWELVE_HOUR_EN builds a 12..11 counter
// with an AM/PM flag. day_pulse marks a carry-caused day rollover.
module counter_hours (
  input logic             clk,
  input logic             reset,
  counter_hours_if.slave  bus
);

`ifdef TWELVE_HOUR_EN
  localparam logic [3:0] UnitsRst = 4'd2;
  localparam logic [1:0] TensRst  = 2'd1;
`else
  localparam logic [3:0] UnitsRst = 4'd0;
  localparam logic [1:0] TensRst  = 2'd0;
`endif

  logic       carry_q, carry_d;
  logic       adj_q, adj_d;
  logic [3:0] units_q, units_d;
  logic [1:0] tens_q, tens_d;
  logic       day_q, day_d;
  logic       carry_adv, adj_adv, advance;
`ifdef TWELVE_HOUR_EN
  logic       pm_q, pm_d;
`endif

  // Edge detection, source selection and next hour value
  always_comb begin
    carry_d   = bus.carry_in;
    adj_d     = bus.adj_in;
    // set_en picks exactly one source, so coincident rises advance only once
    carry_adv = bus.carry_in & ~carry_q & ~bus.set_en;
    adj_adv   = bus.adj_in & ~adj_q & bus.set_en;
    advance   = carry_adv | adj_adv;
    units_d   = units_q;
    tens_d    = tens_q;
    day_d     = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_d      = pm_q;
    if (advance) begin
      if (tens_q == 2'd1 && units_q == 4'd2) begin
        tens_d  = 2'd0;
        units_d = 4'd1;
      end else if (tens_q == 2'd1 && units_q == 4'd1) begin
        tens_d  = 2'd1;
        units_d = 4'd2;
        pm_d    = ~pm_q;
        // Only the PM -> AM transition is a new day
        day_d   = carry_adv & pm_q;
      end else if (units_q == 4'd9) begin
        tens_d  = 2'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
`else
    if (advance) begin
      if (tens_q == 2'd2 && units_q == 4'd3) begin
        tens_d  = 2'd0;
        units_d = 4'd0;
        day_d   = carry_adv;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 2'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
`endif
  end

  // State register; edge trackers reset high so an input already high at release is ignored
  always_ff @(posedge clk) begin
    if (!reset) begin
      carry_q <= 1'b1;
      adj_q   <= 1'b1;
      units_q <= UnitsRst;
      tens_q  <= TensRst;
      day_q   <= 1'b0;
`ifdef TWELVE_HOUR_EN
      pm_q    <= 1'b0;
`endif
    end else begin
      carry_q <= carry_d;
      adj_q   <= adj_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      day_q   <= day_d;
`ifdef TWELVE_HOUR_EN
      pm_q    <= pm_d;
`endif
    end
  end

  assign bus.hour_digit1 = units_q;
  assign bus.hour_digit2 = tens_q;
  assign bus.day_pulse   = day_q;
`ifdef TWELVE_HOUR_EN
  assign bus.pm          = pm_q;
`else
  assign bus.pm          = 1'b0;
`endif

endmodule

// File: tb/tb_counter_hours.sv
// Scoreboard bench for counter_hours. The reference model keeps the time of day as 0..23 and
// converts to the displayed format, so it works for both the 24-hour and 12-hour builds.
module tb_counter_hours;

  logic clk;
  logic reset;
  counter_hours_if bus ();

  counter_hours dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d1;
    logic [1:0] d2;
    logic       day;
    logic       pm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fail;
  int   day_cnt;

  // Reference model state
  int   m_h;
  logic m_cprev;
  logic m_aprev;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic exp_t model_out(input int h, input logic day);
    exp_t e;
    int   disp;
`ifdef TWELVE_HOUR_EN
    disp = (h % 12 == 0) ? 12 : h % 12;
    e.pm = (h >= 12);
`else
    disp = h;
    e.pm = 1'b0;
`endif
    e.d2  = 2'(disp / 10);
    e.d1  = 4'(disp % 10);
    e.day = day;
    return e;
  endfunction

  // One clock: drive inputs, predict and queue the result, then compare after the edge
  task automatic step(input logic rst_n, input logic c, input logic a, input logic s);
    logic cr, ar, adv, day;
    exp_t e, got;
    @(negedge clk);
    reset        = rst_n;
    bus.carry_in = c;
    bus.adj_in   = a;
    bus.set_en   = s;
    day = 1'b0;
    if (!rst_n) begin
      m_h     = 0;
      m_cprev = 1'b1;
      m_aprev = 1'b1;
    end else begin
      cr  = c & ~m_cprev;
      ar  = a & ~m_aprev;
      adv = s ? ar : cr;
      if (adv) begin
        if (m_h == 23) begin
          m_h = 0;
          day = ~s;
        end else begin
          m_h = m_h + 1;
        end
      end
      m_cprev = c;
      m_aprev = a;
    end
    sb_q.push_back(model_out(m_h, day));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      e   = sb_q.pop_front();
      got = '{d1: bus.hour_digit1, d2: bus.hour_digit2, day: bus.day_pulse, pm: bus.pm};
      check_eq("digit1", int'(got.d1), int'(e.d1));
      check_eq("digit2", int'(got.d2), int'(e.d2));
      check_eq("day_pulse", int'(got.day), int'(e.day));
      check_eq("pm", int'(got.pm), int'(e.pm));
    end
    if (bus.day_pulse) day_cnt++;
  endtask

  task automatic carry_rises(input int n, input logic s);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 1'b0, s);
      step(1'b1, 1'b0, 1'b0, s);
    end
  endtask

  task automatic adj_rises(input int n, input logic s);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b1, s);
      step(1'b1, 1'b0, 1'b0, s);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    day_cnt = 0;
  endtask

  function automatic int hour_bcd();
    return int'({bus.hour_digit2, bus.hour_digit1});
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    day_cnt  = 0;
    m_h      = 0;
    m_cprev  = 1'b1;
    m_aprev  = 1'b1;
    reset        = 1'b0;
    bus.carry_in = 1'b1;
    bus.adj_in   = 1'b0;
    bus.set_en   = 1'b0;

    // Reset with carry held high, then release with carry still high: no advance
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef TWELVE_HOUR_EN
    check_eq("reset_hour", hour_bcd(), 'h12);
`else
    check_eq("reset_hour", hour_bcd(), 'h00);
`endif
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef TWELVE_HOUR_EN
    check_eq("release_no_adv", hour_bcd(), 'h12);
`else
    check_eq("release_no_adv", hour_bcd(), 'h00);
`endif

`ifndef TWELVE_HOUR_EN
    // Ten carries: 00 -> 10
    do_reset();
    carry_rises(10, 1'b0);
    check_eq("count_10", hour_bcd(), 'h10);

    // Full day: 24 carries back to 00 with one day pulse
    do_reset();
    carry_rises(24, 1'b0);
    check_eq("count_24", hour_bcd(), 'h00);
    check_eq("day_pulses_24", day_cnt, 1);

    // Level held high for 50 cycles advances once: 05 -> 06
    do_reset();
    carry_rises(5, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("level_hold", hour_bcd(), 'h06);

    // Set mode from 22: 3 adj rises count, 2 carry rises ignored, adj wrap does not pulse
    do_reset();
    carry_rises(22, 1'b0);
    day_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("set_toggle", hour_bcd(), 'h22);
    adj_rises(1, 1'b1);
    carry_rises(1, 1'b1);
    adj_rises(1, 1'b1);
    carry_rises(1, 1'b1);
    adj_rises(1, 1'b1);
    check_eq("set_mode", hour_bcd(), 'h01);
    check_eq("set_no_pulse", day_cnt, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    adj_rises(1, 1'b0);
    check_eq("adj_ignored", hour_bcd(), 'h01);

    // Coincident carry and adj rise with set_en=0: 09 -> 10 exactly
    do_reset();
    carry_rises(9, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("coincide", hour_bcd(), 'h10);
`else
    // 12-hour: 12 carries to 12 PM without pulse, 12 more back to 12 AM with one pulse
    do_reset();
    carry_rises(12, 1'b0);
    check_eq("pm_hour", hour_bcd(), 'h12);
    check_eq("pm_flag", int'(bus.pm), 1);
    check_eq("pm_no_pulse", day_cnt, 0);
    carry_rises(12, 1'b0);
    check_eq("am_hour", hour_bcd(), 'h12);
    check_eq("am_flag", int'(bus.pm), 0);
    check_eq("am_pulse", day_cnt, 1);
`endif

    // Reset asserted mid-count with a coincident rise discards it
    do_reset();
    carry_rises(3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic checked against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
